// File: rtl/ram_pkg.sv
// Shared types and sizing for the 32x4 dual-port RAM writer and reader/display side.
package ram_pkg;

  localparam int unsigned RAM_DATA_W = 4;
  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DONE
  } ram_wr_state_t;

endpackage

// File: rtl/ram_stream_writer_addr_counter.sv
// Write-address counter: async active-low reset, sync clear, increment enable,
// terminal-count flag on the last RAM address.
module addr_counter #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == '1);

endmodule

// File: rtl/ram_stream_writer.sv
// RAM write-side sequencer: streams handshaked words or a constant fill into the
// ram32x4 write port with auto-incrementing addresses.
module ram_stream_writer
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear_mode,
  input  logic [DATA_W-1:0] clear_value,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  ram_wr_state_t     state;
  logic [DATA_W-1:0] clear_lat;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_tc;
  logic              step;
  logic              cnt_clr;
  logic [DATA_W-1:0] wsel;

  // A write step ignores abort so a write registered at the abort edge still issues.
  always_comb begin
    step    = 1'b0;
    cnt_clr = 1'b0;
    wsel    = in_data;
    case (state)
      ST_CLEAR: begin
        step = 1'b1;
        wsel = clear_lat;
      end
      ST_STREAM: step    = in_valid;
      ST_IDLE:   cnt_clr = start && !abort;
      default:   step    = 1'b0;
    endcase
  end

  addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (step),
    .count   (cnt),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wren          <= 1'b0;
      wraddress     <= '0;
      wdata         <= '0;
      words_written <= '0;
      clear_lat     <= '0;
    end else begin
      wren <= step;
      if (step) begin
        wraddress <= cnt;
        wdata     <= wsel;
        if (words_written != FULL_CNT) begin
          words_written <= words_written + 1'b1;
        end
      end
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            words_written <= '0;
            clear_lat     <= clear_value;
            state         <= clear_mode ? ST_CLEAR : ST_STREAM;
          end
        end
        ST_CLEAR: begin
          if (abort)       state <= ST_IDLE;
          else if (cnt_tc) state <= ST_DONE;
        end
        ST_STREAM: begin
          if (abort)                   state <= ST_IDLE;
          else if (in_valid && cnt_tc) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state == ST_STREAM);
  assign busy     = (state == ST_CLEAR) || (state == ST_STREAM);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_ram_stream_writer.sv
// Scoreboard bench for ram_stream_writer: drivers queue expected writes, a monitor
// pops and compares each registered RAM write.
module tb_ram_stream_writer;

  typedef struct packed {
    logic [4:0] a;
    logic [3:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       clear_mode;
  logic [3:0] clear_value;
  logic       abort;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wren;
  logic [4:0] wraddress;
  logic [3:0] wdata;
  logic       busy;
  logic       done;
  logic [5:0] words_written;

  wr_t        sb_q[$];
  logic [3:0] mem[32];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         wr_pass = 0;

  always #5 clk = ~clk;

  ram_stream_writer #(.DATA_W(4), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .clear_mode    (clear_mode),
    .clear_value   (clear_value),
    .abort         (abort),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wren          (wren),
    .wraddress     (wraddress),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input logic [3:0] d);
    wr_t e;
    e.a = 5'(a);
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic mode, input logic [3:0] val);
    start       = 1'b1;
    clear_mode  = mode;
    clear_value = val;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt == prev && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, done_cnt, prev + 1);
  endtask

  // Monitor: every registered write must match the head of the scoreboard.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (wren) begin
          wr_pass = (wraddress == 5'd0) ? 1 : wr_pass + 1;
          mem[wraddress] = wdata;
          check("wr_expected", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wr_addr", int'(wraddress), int'(e.a));
            check("wr_data", int'(wdata), int'(e.d));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_after_last_write", wr_pass, 32);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  i;
    int  c;
    bit  found;
    reset_n     = 1'b0;
    start       = 1'b0;
    clear_mode  = 1'b0;
    clear_value = 4'h0;
    abort       = 1'b0;
    in_data     = 4'h0;
    in_valid    = 1'b0;

    // Reset, then idle with a word offered that must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", int'(wren), 0);
    check("rst_ww", int'(words_written), 0);
    check("rst_waddr", int'(wraddress), 0);
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_wren", int'(wren), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_ready", int'(in_ready), 0);
      check("idle_ww", int'(words_written), 0);
    end
    tick();
    in_valid = 1'b0;

    // Clear fill with 4'hA
    for (int k = 0; k < 32; k++) push_exp(k, 4'hA);
    start_op(1'b1, 4'hA);
    wait_done(0, 40, "clear_done");
    check("clear_ww", int'(words_written), 32);
    @(negedge clk);
    check("clear_done_one_cycle", int'(done), 0);
    check("clear_busy_after", int'(busy), 0);
    check("clear_sb_empty", sb_q.size(), 0);
    for (int k = 0; k < 32; k++) check("clear_mem", int'(mem[k]), 10);

    // Stream with a gap every third cycle and a stray start mid-stream
    tick();
    start_op(1'b0, 4'h0);
    i = 0;
    c = 0;
    while (i < 32 && c < 200) begin
      if (c % 3 == 2) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = 4'(i);
      end
      if (c == 5) begin
        start      = 1'b1;
        clear_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_exp(i, 4'(i));
        i++;
      end
      tick();
      c++;
    end
    start = 1'b0;
    check("stream_beats", i, 32);
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (4) tick();
    in_valid = 1'b0;
    wait_done(1, 10, "stream_done");
    check("stream_ww", int'(words_written), 32);
    check("stream_ready_after", int'(in_ready), 0);
    for (int k = 0; k < 32; k++) check("stream_mem", int'(mem[k]), k % 16);

    // Abort and start together in IDLE: abort wins
    start      = 1'b1;
    abort      = 1'b1;
    clear_mode = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_start_busy", int'(busy), 0);
    end

    // Abort after 10 streamed words with a beat in the same cycle
    tick();
    start_op(1'b0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 4'((k * 3) & 15);
      push_exp(k, 4'((k * 3) & 15));
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 1);
      tick();
    end
    in_data = 4'hE;
    abort   = 1'b1;
    push_exp(10, 4'hE);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_last_wren", int'(wren), 1);
    check("abort_ww", int'(words_written), 11);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 2);
    check("abort_ww_hold", int'(words_written), 11);
    check("abort_sb_empty", sb_q.size(), 0);

    // Fresh clear after abort restarts at address 0
    tick();
    for (int k = 0; k < 32; k++) push_exp(k, 4'h3);
    start_op(1'b1, 4'h3);
    wait_done(2, 40, "restart_done");
    check("restart_ww", int'(words_written), 32);
    for (int k = 0; k < 32; k++) check("restart_mem", int'(mem[k]), 3);

    // Async reset mid-clear at address 17
    tick();
    for (int k = 0; k < 32; k++) push_exp(k, 4'h6);
    start_op(1'b1, 4'h6);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (wren && wraddress == 5'd17) found = 1'b1;
    end
    check("reset_addr17_seen", int'(found), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_wren_async", int'(wren), 0);
    check("reset_busy_async", int'(busy), 0);
    check("reset_ww_async", int'(words_written), 0);
    sb_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_ww", int'(words_written), 0);
    tick();
    for (int k = 0; k < 32; k++) push_exp(k, 4'h9);
    start_op(1'b1, 4'h9);
    wait_done(3, 40, "post_reset_done");
    check("post_reset_ww_full", int'(words_written), 32);
    repeat (2) @(negedge clk);
    check("final_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_stream_writer.md
Name: ram_stream_writer

Overview:
Write-side sequencer for the 32x4 dual-port RAM, the counterpart to the one-second scanning reader that displays RAM contents on HEX. It accepts a stream of data words over a valid/ready handshake, or self-generates a constant fill pattern, and drives the RAM write port with auto-incrementing addresses. Sits between a data source (switch debouncer, UART receiver, test pattern logic) and the ram32x4 wren/wraddress/data pins.

Parameters:
DATA_W, 4, RAM word width
ADDR_W, 5, RAM address width; depth = 2**ADDR_W (32)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin an operation; sampled only in IDLE
clear_mode  input  1  sampled with start: 1 = fill all words with clear_value, 0 = stream mode
clear_value  input  DATA_W  fill word for clear mode, sampled with start
abort  input  1  returns to IDLE from any state; in-flight write still completes
in_data  input  DATA_W  stream data word
in_valid  input  1  source has a word on in_data
in_ready  output  1  writer accepts a word this cycle
wren  output  1  RAM write enable
wraddress  output  ADDR_W  RAM write address
wdata  output  DATA_W  RAM write data
busy  output  1  high in CLEAR or STREAM
done  output  1  one-cycle pulse on completion of a full pass
words_written  output  ADDR_W+1  words written in the current/last pass (0..32)

Behaviour:
- Reset (reset_n low, async): state IDLE; wren=0, wraddress=0, wdata=0, in_ready=0, busy=0, done=0, words_written=0; internal address counter 0.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE: start=1 & clear_mode=1 -> CLEAR; start=1 & clear_mode=0 -> STREAM. On either, address counter and words_written clear to 0; clear_value latched. start outside IDLE is ignored.
- CLEAR: one write per cycle, no handshake. Each cycle registers wren=1, wraddress=counter, wdata=latched clear_value; counter increments. After writing address 2**ADDR_W-1 -> DONE.
- STREAM: in_ready=1 (decoded from state register, no combinational path from in_valid). Beat = in_valid & in_ready. On a beat: next edge registers wren=1, wraddress=counter, wdata=in_data; counter increments. No beat -> wren=0 next cycle. After the beat for address 2**ADDR_W-1 -> DONE; in_ready drops the same edge.
- Latency: beat/clear step at edge N -> wren, wraddress, wdata valid during cycle N+1, held exactly one cycle. All three outputs registered.
- words_written increments with each registered write (same edge wren rises); saturates at 2**ADDR_W.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0, then IDLE. words_written holds until next start.
- Address wrap: counter is ADDR_W bits; the last pass write is address 31; counter wraps to 0 at DONE entry, never writing address 0 twice in one pass.
- abort: highest priority in CLEAR/STREAM/DONE -> IDLE next edge, no done pulse; a write registered at that same edge still issues (wren high one cycle); words_written reflects writes actually issued.
- abort and start in IDLE same cycle: abort wins, stay IDLE.
- in_valid while not in STREAM: ignored, no write.
- Reset mid-operation: immediate return to reset values; wren drops asynchronously.
- busy = state in {CLEAR, STREAM}.

Decomposition:
- Shared package ram_pkg: state enum type (IDLE, CLEAR, STREAM, DONE), RAM_DATA_W=4, RAM_ADDR_W=5, RAM_DEPTH=32 constants, shared with the reader/display side.
- One sub-module: addr_counter (ADDR_W-bit counter with async active-low reset, sync clear, increment enable, terminal-count flag at 2**ADDR_W-1). FSM, handshake and output registers stay in ram_stream_writer.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release, no start for 10 cycles -> wren=0, busy=0, done=0, words_written=0 throughout.
- Clear fill: start=1, clear_mode=1, clear_value=4'hA for one cycle -> 32 consecutive wren pulses, wraddress 0..31, wdata=4'hA; done pulses one cycle after address 31; words_written=32; behavioural RAM model all 4'hA.
- Stream with gaps: clear_mode=0, send data i[3:0] for i=0..31 with in_valid low every third cycle -> RAM addr i holds i[3:0]; wren only the cycle after each beat; done once; words_written=32.
- Backpressure/ignore: in_valid=1 with in_data=4'h5 while IDLE and during DONE -> no wren; a start arriving during STREAM is ignored (address sequence unbroken).
- Abort: stream 10 words then abort with in_valid=1 same cycle -> 11th write (addr 10) issues, state IDLE next edge, no done pulse, words_written=11; fresh start restarts at address 0.
- Async reset mid-clear: pull reset_n low between clock edges at address 17 -> wren, busy drop immediately; after release, words_written=0 and a new clear starts at address 0.
